// File: rtl/fu_add_issue_ctrl.sv
// rtl/fu_add_issue_ctrl.sv - adder-FU initiator: request in, FU operands/on_off out, ack-gated result capture, response out
// Optional build macro: FU_TIMEOUT_EN (adds a WAIT watchdog that aborts with resp_err=1 after TIMEOUT_CYCLES)

module fu_add_issue_ctrl #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_c,
    output logic             resp_carry,
    output logic             resp_err,
    output logic             busy,
    output logic [WIDTH-1:0] fu_a,
    output logic [WIDTH-1:0] fu_b,
    output logic             fu_on_off,
    input  logic [WIDTH-1:0] fu_c,
    input  logic             fu_carry_out,
    input  logic             fu_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;       // request taken this edge
    logic capture;      // FU result taken this edge
    logic timeout_hit;  // watchdog abort this edge
    logic resp_done;    // response handshake completes this edge

`ifdef FU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    // The edge that would close the TIMEOUT_CYCLES-th ack-less WAIT cycle aborts; an ack on that edge wins.
    assign timeout_hit = (state == S_WAIT) && !fu_ack && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Count WAIT cycles without ack; cleared when a request is accepted.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            wait_cnt <= '0;
        end else if ((state == S_WAIT) && !fu_ack && !timeout_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    // Without the watchdog WAIT only ends on an ack.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; the response only retires once the FU has dropped its ack.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        resp_done = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fu_ack) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end else if (timeout_hit) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready && !fu_ack) begin
                    resp_done = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

    // Registered FU drive and response holding registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fu_a       <= '0;
            fu_b       <= '0;
            fu_on_off  <= 1'b0;
            resp_c     <= '0;
            resp_carry <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                fu_a      <= req_a;
                fu_b      <= req_b;
                fu_on_off <= 1'b1;
            end
            if (capture) begin
                resp_c     <= fu_c;
                resp_carry <= fu_carry_out;
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                fu_on_off  <= 1'b0;
            end else if (timeout_hit) begin
                resp_c     <= '0;
                resp_carry <= 1'b0;
                resp_valid <= 1'b1;
                resp_err   <= 1'b1;
                fu_on_off  <= 1'b0;
            end
            if (resp_done) begin
                resp_valid <= 1'b0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fu_add_issue_ctrl.sv
// tb/tb_fu_add_issue_ctrl.sv - scoreboard bench for fu_add_issue_ctrl with a behavioural adder-FU model

module tb_fu_add_issue_ctrl;

    localparam int W   = 16;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [W-1:0]  req_a = '0;
    logic [W-1:0]  req_b = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [W-1:0]  resp_c;
    logic          resp_carry;
    logic          resp_err;
    logic          busy;
    logic [W-1:0]  fu_a;
    logic [W-1:0]  fu_b;
    logic          fu_on_off;
    logic [W-1:0]  fu_c = '0;
    logic          fu_carry_out = 1'b0;
    logic          fu_ack = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fu_delay = 1;
    int on_cnt = 0;
    int acc_cycle = 0;
    int acc_prev  = 0;

    logic [W+1:0] sb[$];

    fu_add_issue_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_c(resp_c),
        .resp_carry(resp_carry), .resp_err(resp_err), .busy(busy),
        .fu_a(fu_a), .fu_b(fu_b), .fu_on_off(fu_on_off),
        .fu_c(fu_c), .fu_carry_out(fu_carry_out), .fu_ack(fu_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Adder FU: with on_off held, it produces a+b and raises ack on the fu_delay-th edge; on_off low clears it.
    always @(posedge clk) begin
        if (fu_on_off) begin
            on_cnt <= on_cnt + 1;
            if (on_cnt + 1 >= fu_delay) begin
                {fu_carry_out, fu_c} <= {1'b0, fu_a} + {1'b0, fu_b};
                fu_ack <= 1'b1;
            end
        end else begin
            on_cnt       <= 0;
            fu_ack       <= 1'b0;
            fu_c         <= '0;
            fu_carry_out <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected {err, carry, sum}: the FU ack reaches the controller one edge after the FU raises it.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input int d);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef FU_TIMEOUT_EN
        if (d + 1 > TMO) return {1'b1, 1'b0, {W{1'b0}}};
`endif
        if (d < 0) return '0;
        return {1'b0, s};
    endfunction

    // Response monitor: a handshake happens on the next edge when valid, ready and no ack are seen now.
    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready && !fu_ack) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected actual=%h required=none", {resp_err, resp_carry, resp_c});
            end else begin
                check("resp", 32'({resp_err, resp_carry, resp_c}), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input int d);
        int n;
        bit got;
        fu_delay  = d;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        got       = 1'b0;
        n         = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            if (req_ready && !reset) got = 1'b1;
            else n++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=%0d required=<200", n);
        end else begin
            sb.push_back(model(a, b, d));
            tick();
            acc_prev  = acc_cycle;
            acc_cycle = cyc;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            if (rnd) resp_ready = 1'($urandom_range(0, 1));
            tick();
            if (req_ready) done = 1'b1;
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL idle_timeout actual=%0d required=<300", n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset state
        tick(); tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_on_off", 32'(fu_on_off), 32'd0);
        check("rst_fu_a", 32'(fu_a), 32'd0);
        check("rst_resp", 32'({resp_err, resp_carry, resp_c}), 32'd0);
        reset = 1'b0;
        tick();

        // Basic op and its latency
        resp_ready = 1'b1;
        fu_delay   = 1;
        req_a = 16'h1234; req_b = 16'h0001; req_valid = 1'b1;
        sb.push_back(model(16'h1234, 16'h0001, 1));
        tick();                                     // edge E
        req_valid = 1'b0;
        check("e0_on_off", 32'(fu_on_off), 32'd1);
        check("e0_fu_ops", 32'({fu_a, fu_b}), 32'h1234_0001);
        check("e0_req_ready", 32'(req_ready), 32'd0);
        tick();                                     // E+1
        check("e1_resp_valid", 32'(resp_valid), 32'd0);
        tick();                                     // E+2
        check("e2_resp_valid", 32'(resp_valid), 32'd1);
        check("e2_on_off", 32'(fu_on_off), 32'd0);
        wait_idle(1'b0);
        check("done_resp_valid", 32'(resp_valid), 32'd0);

        // Carry out
        issue(16'hFFFF, 16'h0001, 1);
        wait_idle(1'b0);

        // Backpressure, with a second request pending
        resp_ready = 1'b0;
        issue(16'hABCD, 16'h1111, 1);
        k = 0;
        while (!resp_valid && k < 50) begin tick(); k++; end
        req_a = 16'h0003; req_b = 16'h0004; req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_hold", 32'({resp_valid, resp_err, resp_carry, resp_c}), 32'({1'b1, 1'b0, 1'b0, 16'hBCDE}));
            check("bp_blocked", 32'({req_ready, busy}), 32'b01);
        end
        resp_ready = 1'b1;
        issue(16'h0003, 16'h0004, 1);
        wait_idle(1'b0);

        // Back-to-back with req_valid held
        issue(16'h00FF, 16'h0001, 1);
        issue(16'h8000, 16'h8000, 1);
        check("b2b_gap_ge4", 32'(acc_cycle - acc_prev >= 4), 32'd1);
        wait_idle(1'b0);

        // Reset while waiting for the FU
        issue(16'h1111, 16'h2222, 3);
        reset = 1'b1;
        sb.delete();
        tick();
        check("rstw_state", 32'({fu_on_off, resp_valid, req_ready}), 32'b001);
        reset = 1'b0;
        tick(); tick();
        issue(16'h0002, 16'h0003, 1);
        wait_idle(1'b0);

        // Random operands, FU latency and response backpressure
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 8 == 0) ra = 16'hFFFF;
            issue(ra, rb, int'($urandom_range(1, 4)));
            wait_idle(1'b1);
        end
        resp_ready = 1'b1;
        wait_idle(1'b0);

`ifdef FU_TIMEOUT_EN
        // Ack never arrives: abort after TMO WAIT cycles
        resp_ready = 1'b0;
        issue(16'h1234, 16'h4321, 100000);
        k = 0;
        while (!resp_valid && k < 100) begin tick(); k++; end
        check("tmo_cycles", 32'(k), 32'(TMO));
        check("tmo_resp", 32'({resp_err, resp_carry, resp_c, fu_on_off}), 32'({1'b1, 1'b0, 16'h0, 1'b0}));
        resp_ready = 1'b1;
        wait_idle(1'b0);

        // Ack seen on the last WAIT cycle wins over the abort
        resp_ready = 1'b0;
        issue(16'h0F0F, 16'h00F1, TMO - 1);
        k = 0;
        while (!resp_valid && k < 100) begin tick(); k++; end
        check("tmo_edge_cycles", 32'(k), 32'(TMO));
        check("tmo_edge_err", 32'(resp_err), 32'd0);
        resp_ready = 1'b1;
        wait_idle(1'b0);
`endif

        tick(); tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
